// File: rtl/core_pkg.sv
// Shared types for the EX-stage forwarding control: mux select codes,
// the per-stage register-info entry and the x0 constant.
package core_pkg;

  localparam int PKG_REG_AW = 5;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef struct packed {
    logic                  valid;
    logic [PKG_REG_AW-1:0] rs1;
    logic [PKG_REG_AW-1:0] rs2;
    logic                  use_rs1;
    logic                  use_rs2;
    logic [PKG_REG_AW-1:0] rd;
    logic                  reg_write;
    logic                  mem_read;
  } stage_info_t;

  localparam logic [PKG_REG_AW-1:0] REG_X0 = '0;

  // x0 is hardwired to zero, so an instruction targeting it never produces a value.
  function automatic logic is_writer(input stage_info_t s);
    return s.valid & s.reg_write & (s.rd != REG_X0);
  endfunction

endpackage

// File: rtl/fwd_sel_logic.sv
// Per-operand forwarding priority selector: MEM result beats WB result beats regfile.
// Also flags a load sitting in MEM that matches, which the load-use stall must prevent.
module fwd_sel_logic
  import core_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic              use_src,
  input  logic [REG_AW-1:0] src,
  input  logic              mem_writer,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_load,
  input  logic              wb_writer,
  input  logic [REG_AW-1:0] wb_rd,
  output logic [1:0]        sel,
  output logic              mem_load_hit
);

  fwd_sel_t sel_e;
  logic     mem_match;
  logic     wb_match;

  always_comb begin
    sel_e     = FWD_RF;
    mem_match = use_src & mem_writer & (mem_rd == src);
    wb_match  = use_src & wb_writer & (wb_rd == src);
    // A load's data is not ready in MEM, so it can only be taken once it reaches WB.
    if (mem_match && !mem_load) begin
      sel_e = FWD_MEM;
    end else if (wb_match) begin
      sel_e = FWD_WB;
    end
    mem_load_hit = mem_match & mem_load;
  end

  assign sel = sel_e;

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// EX-stage forwarding select and load-use stall control with its own EX/MEM/WB info pipeline.
// Optional saturating perf counters are built when FWD_HAZARD_PERF_EN is defined.
module fwd_hazard_ctrl
  import core_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic              id_use_rs1_i,
  input  logic              id_use_rs2_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              id_reg_write_i,
  input  logic              id_mem_read_i,
  input  logic              flush_i,
  output logic [1:0]        fwd_a_sel_o,
  output logic [1:0]        fwd_b_sel_o,
  output logic              stall_o
`ifdef FWD_HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0]  perf_stall_cnt_o,
  output logic [CNT_W-1:0]  perf_fwd_cnt_o
`endif
);

  // The stage entry struct is sized by the package, so the port width must agree with it.
  if (REG_AW != PKG_REG_AW || CNT_W < 1) begin : g_param_chk
    $error("fwd_hazard_ctrl: REG_AW must equal PKG_REG_AW and CNT_W must be positive");
  end

  stage_info_t ex_q, mem_q, wb_q, ex_d;
  logic        load_hit_a, load_hit_b;
  logic        unused_fields;

  always_comb begin
    ex_d = '0;
    if (id_valid_i && !stall_o && !flush_i) begin
      ex_d.valid     = 1'b1;
      ex_d.rs1       = id_rs1_i;
      ex_d.rs2       = id_rs2_i;
      ex_d.use_rs1   = id_use_rs1_i;
      ex_d.use_rs2   = id_use_rs2_i;
      ex_d.rd        = id_rd_i;
      ex_d.reg_write = id_reg_write_i;
      ex_d.mem_read  = id_mem_read_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= ex_q;
      wb_q  <= mem_q;
    end
  end

  assign stall_o = id_valid_i & is_writer(ex_q) & ex_q.mem_read &
                   ((id_use_rs1_i & (ex_q.rd == id_rs1_i)) |
                    (id_use_rs2_i & (ex_q.rd == id_rs2_i)));

  fwd_sel_logic #(.REG_AW(REG_AW)) u_sel_a (
    .use_src      (ex_q.valid & ex_q.use_rs1),
    .src          (ex_q.rs1),
    .mem_writer   (is_writer(mem_q)),
    .mem_rd       (mem_q.rd),
    .mem_load     (mem_q.mem_read),
    .wb_writer    (is_writer(wb_q)),
    .wb_rd        (wb_q.rd),
    .sel          (fwd_a_sel_o),
    .mem_load_hit (load_hit_a)
  );

  fwd_sel_logic #(.REG_AW(REG_AW)) u_sel_b (
    .use_src      (ex_q.valid & ex_q.use_rs2),
    .src          (ex_q.rs2),
    .mem_writer   (is_writer(mem_q)),
    .mem_rd       (mem_q.rd),
    .mem_load     (mem_q.mem_read),
    .wb_writer    (is_writer(wb_q)),
    .wb_rd        (wb_q.rd),
    .sel          (fwd_b_sel_o),
    .mem_load_hit (load_hit_b)
  );

  // Source fields are only needed while an entry is in EX.
  assign unused_fields = ^{mem_q.rs1, mem_q.rs2, mem_q.use_rs1, mem_q.use_rs2,
                           wb_q.rs1, wb_q.rs2, wb_q.use_rs1, wb_q.use_rs2, wb_q.mem_read};

  a_no_load_in_mem_fwd: assert property (@(posedge clk) disable iff (!rst_n)
    !(load_hit_a | load_hit_b));

`ifdef FWD_HAZARD_PERF_EN
  logic fwd_any;
  assign fwd_any = (fwd_a_sel_o != 2'b00) | (fwd_b_sel_o != 2'b00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cnt_o <= '0;
      perf_fwd_cnt_o   <= '0;
    end else begin
      if (stall_o && (perf_stall_cnt_o != {CNT_W{1'b1}})) begin
        perf_stall_cnt_o <= perf_stall_cnt_o + CNT_W'(1);
      end
      if (fwd_any && (perf_fwd_cnt_o != {CNT_W{1'b1}})) begin
        perf_fwd_cnt_o <= perf_fwd_cnt_o + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl: forwarding priority, load-use stall, flush, x0 and reset.
module tb_fwd_hazard_ctrl;

  logic       clk;
  logic       rst_n;
  logic       id_valid_i;
  logic [4:0] id_rs1_i;
  logic [4:0] id_rs2_i;
  logic       id_use_rs1_i;
  logic       id_use_rs2_i;
  logic [4:0] id_rd_i;
  logic       id_reg_write_i;
  logic       id_mem_read_i;
  logic       flush_i;
  logic [1:0] fwd_a_sel_o;
  logic [1:0] fwd_b_sel_o;
  logic       stall_o;

  int cmps = 0;
  int errs = 0;

  fwd_hazard_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .id_valid_i     (id_valid_i),
    .id_rs1_i       (id_rs1_i),
    .id_rs2_i       (id_rs2_i),
    .id_use_rs1_i   (id_use_rs1_i),
    .id_use_rs2_i   (id_use_rs2_i),
    .id_rd_i        (id_rd_i),
    .id_reg_write_i (id_reg_write_i),
    .id_mem_read_i  (id_mem_read_i),
    .flush_i        (flush_i),
    .fwd_a_sel_o    (fwd_a_sel_o),
    .fwd_b_sel_o    (fwd_b_sel_o),
    .stall_o        (stall_o)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2, input logic [4:0] rd,
                       input logic rw, input logic mr);
    id_valid_i     = v;
    id_rs1_i       = rs1;
    id_rs2_i       = rs2;
    id_use_rs1_i   = u1;
    id_use_rs2_i   = u2;
    id_rd_i        = rd;
    id_reg_write_i = rw;
    id_mem_read_i  = mr;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    idle();
    flush_i = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    flush_i = 1'b0;
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b1);
    #2;
    cmps++; if (fwd_a_sel_o !== 2'b00) begin errs++; $display("FAIL rst_a: got %b want 00", fwd_a_sel_o); end
    cmps++; if (fwd_b_sel_o !== 2'b00) begin errs++; $display("FAIL rst_b: got %b want 00", fwd_b_sel_o); end
    cmps++; if (stall_o !== 1'b0) begin errs++; $display("FAIL rst_stall: got %b want 0", stall_o); end
    #10 rst_n = 1'b1;
    drain();
  endtask

  task automatic test_mem_wb_fwd();
    // add x5 <- x1,x2
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);
    tick();
    // consumer: rs1=x5, rs2=x3, writes x8
    drive(1'b1, 5'd5, 5'd3, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);
    #1;
    cmps++; if (stall_o !== 1'b0) begin errs++; $display("FAIL alu_nostall: got %b want 0", stall_o); end
    tick();
    // second consumer: rs1=x5 only
    drive(1'b1, 5'd5, 5'd4, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0);
    #1;
    cmps++; if (fwd_a_sel_o !== 2'b10) begin errs++; $display("FAIL mem_fwd_a: got %b want 10", fwd_a_sel_o); end
    cmps++; if (fwd_b_sel_o !== 2'b00) begin errs++; $display("FAIL mem_fwd_b: got %b want 00", fwd_b_sel_o); end
    tick();
    idle();
    #1;
    cmps++; if (fwd_a_sel_o !== 2'b01) begin errs++; $display("FAIL wb_fwd_a: got %b want 01", fwd_a_sel_o); end
    cmps++; if (fwd_b_sel_o !== 2'b00) begin errs++; $display("FAIL wb_fwd_b: got %b want 00", fwd_b_sel_o); end
    drain();
  endtask

  task automatic test_load_use();
    // lw x6, 0(x1)
    drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b1);
    tick();
    // add x10 <- x2, x6
    drive(1'b1, 5'd2, 5'd6, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0);
    #1;
    cmps++; if (stall_o !== 1'b1) begin errs++; $display("FAIL lu_stall: got %b want 1", stall_o); end
    cmps++; if (fwd_b_sel_o !== 2'b00) begin errs++; $display("FAIL lu_b0: got %b want 00", fwd_b_sel_o); end
    tick();
    // IF/ID held, so the add is presented again; EX now holds the bubble
    #1;
    cmps++; if (stall_o !== 1'b0) begin errs++; $display("FAIL lu_stall_once: got %b want 0", stall_o); end
    cmps++; if (fwd_b_sel_o !== 2'b00) begin errs++; $display("FAIL lu_bubble_b: got %b want 00", fwd_b_sel_o); end
    cmps++; if (fwd_a_sel_o !== 2'b00) begin errs++; $display("FAIL lu_bubble_a: got %b want 00", fwd_a_sel_o); end
    tick();
    idle();
    #1;
    cmps++; if (fwd_b_sel_o !== 2'b01) begin errs++; $display("FAIL lu_wb_b: got %b want 01", fwd_b_sel_o); end
    cmps++; if (fwd_a_sel_o !== 2'b00) begin errs++; $display("FAIL lu_wb_a: got %b want 00", fwd_a_sel_o); end
    cmps++; if (stall_o !== 1'b0) begin errs++; $display("FAIL lu_after: got %b want 0", stall_o); end
    drain();
  endtask

  task automatic test_mem_wb_priority();
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd7, 5'd7, 1'b1, 1'b1, 5'd12, 1'b1, 1'b0);
    tick();
    idle();
    #1;
    cmps++; if (fwd_a_sel_o !== 2'b10) begin errs++; $display("FAIL both_a: got %b want 10", fwd_a_sel_o); end
    cmps++; if (fwd_b_sel_o !== 2'b10) begin errs++; $display("FAIL both_b: got %b want 10", fwd_b_sel_o); end
    drain();
    // same rd in MEM but without reg_write: WB must be chosen
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd7, 5'd1, 1'b1, 1'b1, 5'd12, 1'b1, 1'b0);
    tick();
    idle();
    #1;
    cmps++; if (fwd_a_sel_o !== 2'b01) begin errs++; $display("FAIL nowr_a: got %b want 01", fwd_a_sel_o); end
    cmps++; if (fwd_b_sel_o !== 2'b00) begin errs++; $display("FAIL nowr_b: got %b want 00", fwd_b_sel_o); end
    drain();
  endtask

  task automatic test_x0();
    // lw x0 followed by consumers of x0
    drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1);
    tick();
    drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd13, 1'b1, 1'b0);
    #1;
    cmps++; if (stall_o !== 1'b0) begin errs++; $display("FAIL x0_stall: got %b want 0", stall_o); end
    tick();
    drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd14, 1'b1, 1'b0);
    #1;
    cmps++; if (fwd_a_sel_o !== 2'b00) begin errs++; $display("FAIL x0_mem_a: got %b want 00", fwd_a_sel_o); end
    cmps++; if (fwd_b_sel_o !== 2'b00) begin errs++; $display("FAIL x0_mem_b: got %b want 00", fwd_b_sel_o); end
    tick();
    idle();
    #1;
    cmps++; if (fwd_a_sel_o !== 2'b00) begin errs++; $display("FAIL x0_wb_a: got %b want 00", fwd_a_sel_o); end
    drain();
  endtask

  task automatic test_flush();
    // lw x11, then a dependent add flushed while stalling
    drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd11, 1'b1, 1'b1);
    tick();
    drive(1'b1, 5'd11, 5'd2, 1'b1, 1'b0, 5'd15, 1'b1, 1'b0);
    flush_i = 1'b1;
    #1;
    cmps++; if (stall_o !== 1'b1) begin errs++; $display("FAIL fl_stall: got %b want 1", stall_o); end
    tick();
    flush_i = 1'b0;
    drive(1'b1, 5'd12, 5'd13, 1'b1, 1'b1, 5'd16, 1'b1, 1'b0);
    #1;
    cmps++; if (stall_o !== 1'b0) begin errs++; $display("FAIL fl_no_restall: got %b want 0", stall_o); end
    cmps++; if (fwd_a_sel_o !== 2'b00) begin errs++; $display("FAIL fl_slot_a: got %b want 00", fwd_a_sel_o); end
    tick();
    idle();
    #1;
    cmps++; if (fwd_a_sel_o !== 2'b00) begin errs++; $display("FAIL fl_next_a: got %b want 00", fwd_a_sel_o); end
    drain();
    // flush without stall: the flushed writer must not forward
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd15, 1'b1, 1'b0);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    drive(1'b1, 5'd15, 5'd15, 1'b1, 1'b1, 5'd17, 1'b1, 1'b0);
    tick();
    idle();
    #1;
    cmps++; if (fwd_a_sel_o !== 2'b00) begin errs++; $display("FAIL fl_kill_a: got %b want 00", fwd_a_sel_o); end
    cmps++; if (fwd_b_sel_o !== 2'b00) begin errs++; $display("FAIL fl_kill_b: got %b want 00", fwd_b_sel_o); end
    drain();
  endtask

  task automatic test_async_reset();
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd20, 1'b1, 1'b0);
    tick();
    // lw x21, 0(x20)
    drive(1'b1, 5'd20, 5'd0, 1'b1, 1'b0, 5'd21, 1'b1, 1'b1);
    tick();
    drive(1'b1, 5'd2, 5'd21, 1'b1, 1'b1, 5'd22, 1'b1, 1'b0);
    #1;
    cmps++; if (fwd_a_sel_o !== 2'b10) begin errs++; $display("FAIL ar_pre_a: got %b want 10", fwd_a_sel_o); end
    cmps++; if (stall_o !== 1'b1) begin errs++; $display("FAIL ar_pre_stall: got %b want 1", stall_o); end
    #2 rst_n = 1'b0;
    #1;
    cmps++; if (fwd_a_sel_o !== 2'b00) begin errs++; $display("FAIL ar_a: got %b want 00", fwd_a_sel_o); end
    cmps++; if (fwd_b_sel_o !== 2'b00) begin errs++; $display("FAIL ar_b: got %b want 00", fwd_b_sel_o); end
    cmps++; if (stall_o !== 1'b0) begin errs++; $display("FAIL ar_stall: got %b want 0", stall_o); end
    #2 rst_n = 1'b1;
    drive(1'b1, 5'd20, 5'd21, 1'b1, 1'b1, 5'd23, 1'b1, 1'b0);
    #1;
    cmps++; if (stall_o !== 1'b0) begin errs++; $display("FAIL ar_post_stall: got %b want 0", stall_o); end
    tick();
    idle();
    #1;
    cmps++; if (fwd_a_sel_o !== 2'b00) begin errs++; $display("FAIL ar_post_a: got %b want 00", fwd_a_sel_o); end
    cmps++; if (fwd_b_sel_o !== 2'b00) begin errs++; $display("FAIL ar_post_b: got %b want 00", fwd_b_sel_o); end
    drain();
  endtask

  initial begin
    test_reset();
    test_mem_wb_fwd();
    test_load_use();
    test_mem_wb_priority();
    test_x0();
    test_flush();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
- Control end of the EX-stage operand-forwarding path.
- Tracks destination-register info of in-flight instructions through EX/MEM/WB in its own pipeline registers.
- Generates the 2-bit select codes that drive the EX-stage 3:1 operand muxes (00 regfile, 01 WB result, 10 MEM result), plus the one-cycle load-use stall.
- Sits beside the ID/EX pipeline registers of the 5-stage RISC-V core.

Parameters:
- REG_AW, 5, register-address width.
- CNT_W, 16, width of the performance counters (optional feature only).

Ports:
- clk  input  1  core clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- id_valid_i  input  1  ID holds a real instruction.
- id_rs1_i  input  REG_AW  ID source register 1.
- id_rs2_i  input  REG_AW  ID source register 2.
- id_use_rs1_i  input  1  ID instruction reads rs1.
- id_use_rs2_i  input  1  ID instruction reads rs2.
- id_rd_i  input  REG_AW  ID destination register.
- id_reg_write_i  input  1  ID instruction writes rd.
- id_mem_read_i  input  1  ID instruction is a load.
- flush_i  input  1  discard the ID instruction (taken branch/jump resolved in EX).
- fwd_a_sel_o  output  2  select for EX operand A mux.
- fwd_b_sel_o  output  2  select for EX operand B mux.
- stall_o  output  1  hold PC and IF/ID; ID/EX receives a bubble.

Behaviour:
- Reset is asynchronous and active-low: all stage valid bits, rd fields and flags clear to 0. On reset, fwd_a_sel_o = fwd_b_sel_o = 2'b00 and stall_o = 0.
- Internal pipeline: EX, MEM and WB entries, each holding {valid, rs1, rs2, use_rs1, use_rs2, rd, reg_write, mem_read}. Every clock edge shifts EX->MEM->WB; the WB entry is dropped. There are no enables; the whole pipeline always advances.
- EX entry load:
  - From ID when id_valid_i=1, stall_o=0 and flush_i=0.
  - Otherwise a bubble is loaded (all fields 0).
  - flush_i has priority over stall_o; both give a bubble.
- Writer qualifier: a stage counts as a writer only if valid & reg_write & rd!=0. x0 is never forwarded.
- fwd_a_sel_o is combinational from registered state (zero input-to-output latency within the EX cycle), in priority order:
  - 2'b10 if EX.use_rs1, MEM is a writer, MEM.rd==EX.rs1, and MEM.mem_read=0.
  - else 2'b01 if EX.use_rs1, WB is a writer, and WB.rd==EX.rs1.
  - else 2'b00.
  - fwd_b_sel_o is identical using rs2.
  - 2'b11 is never produced.
  - If MEM and WB both match, MEM wins (youngest value).
- stall_o is combinational:
  - stall_o = id_valid_i & EX.valid & EX.mem_read & EX.reg_write & EX.rd!=0 & ((id_use_rs1_i & EX.rd==id_rs1_i) | (id_use_rs2_i & EX.rd==id_rs2_i)).
  - It lasts exactly one cycle per load-use pair. After the bubble the load is in WB and the consumer is in EX, so the WB forward (01) resolves it.
- A load in MEM that matches an EX source is illegal, because the stall prevents it. Simulation assertion: MEM.mem_read & match -> error.
- Reset mid-operation: all in-flight entries are discarded immediately; outputs return to 00/0 asynchronously.

Optional Feature:
- Macro: FWD_HAZARD_PERF_EN.
- When defined, adds outputs perf_stall_cnt_o[CNT_W] (increments each cycle stall_o=1) and perf_fwd_cnt_o[CNT_W] (increments each cycle either select is nonzero).
  - Both saturate at all-ones and reset to 0 on rst_n.
- When undefined, neither the ports nor the counters exist, and the rest of the behaviour is identical.

Decomposition:
- Shared package core_pkg:
  - Typedef fwd_sel_t (2-bit enum: FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10).
  - Typedef stage_info_t (the packed entry struct).
  - Constant REG_X0.
- One sub-module, fwd_sel_logic: a combinational per-operand priority selector, instantiated twice (rs1, rs2). The stage registers and stall logic stay in the top.

Test Plan:
- add x5 in ID, next instruction uses rs1=x5 -> one cycle later in EX, fwd_a_sel_o=2'b10. Following instruction using x5 sees 2'b01.
- lw x6 then add rs2=x6 back-to-back -> stall_o=1 for exactly one cycle, EX holds a bubble, then fwd_b_sel_o=2'b01. No 2'b10 at any point.
- Writers to x7 in both MEM and WB, EX rs1=rs2=x7 -> both selects 2'b10.
- Writer rd=x0 with reg_write=1, consumer rs1=x0 -> selects 2'b00, stall_o=0 even if the writer is a load.
- flush_i=1 with a dependent instruction in ID while stall_o=1 -> EX bubble. Next cycle the selects are 00 for that slot and no stall repeats.
- rst_n asserted low asynchronously mid-cycle with forwarding active -> outputs 00/0 immediately. After release, the first instruction sees no stale forwarding.
